// File: rtl/module_bpu.sv
//------------------------------------------------------------------------------
// module_bpu
//   Direct-mapped BTB with 2-bit counters. It supplies a Fetch prediction and
//   carries the predicted-taken bit through D and E. It trains from E-stage
//   branch/jump resolution and keeps resolve and mispredict counts.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module module_bpu #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] pcf_i,
  output logic            predict_takenf_o,
  output logic [XLEN-1:0] pc_predf_o,
  input  logic            stalld_i,
  input  logic            flushd_i,
  input  logic            flushe_i,
  output logic            prediction_bite_o,
  input  logic            branche_i,
  input  logic            jumpe_i,
  input  logic            pcsrce_i,
  input  logic [XLEN-1:0] pce_i,
  input  logic [XLEN-1:0] pctargete_i,
  output logic [31:0]     branch_count_o,
  output logic [31:0]     mispredict_count_o
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - 2 - IDX;

  logic            r_valid  [ENTRIES];
  logic [TAGW-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0] r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];

  logic            r_predd;
  logic            r_prede;
  logic [31:0]     r_branch_cnt;
  logic [31:0]     r_mispred_cnt;

  logic [IDX-1:0]  w_fidx;
  logic [TAGW-1:0] w_ftag;
  logic            w_fhit;
  logic [IDX-1:0]  w_eidx;
  logic [TAGW-1:0] w_etag;
  logic            w_ehit;
  logic            w_upd;
  logic            w_wr_tgt;
  logic [1:0]      w_ctr_cur;
  logic [1:0]      w_ctr_nxt;
  logic            w_unused_bits;

  assign w_unused_bits = ^{pcf_i[1:0], pce_i[1:0]};

  assign w_fidx = pcf_i[IDX+1:2];
  assign w_ftag = pcf_i[XLEN-1:IDX+2];
  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);

  assign predict_takenf_o  = w_fhit && r_ctr[w_fidx][1];
  assign pc_predf_o        = predict_takenf_o ? r_target[w_fidx] : (pcf_i + XLEN'(4));
  assign prediction_bite_o = r_prede;

  assign w_eidx    = pce_i[IDX+1:2];
  assign w_etag    = pce_i[XLEN-1:IDX+2];
  assign w_ehit    = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);
  assign w_upd     = branche_i | jumpe_i;
  assign w_ctr_cur = r_ctr[w_eidx];

  // A jump overrides branche_i, whether it hits or allocates.
  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    w_wr_tgt  = 1'b0;
    if (jumpe_i) begin
      w_ctr_nxt = 2'b11;
      w_wr_tgt  = 1'b1;
    end else if (!w_ehit) begin
      w_ctr_nxt = pcsrce_i ? 2'b10 : 2'b01;
      w_wr_tgt  = 1'b1;
    end else if (pcsrce_i) begin
      w_ctr_nxt = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'b01;
      w_wr_tgt  = 1'b1;
    end else begin
      w_ctr_nxt = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_upd) begin
      r_valid[w_eidx] <= 1'b1;
      r_tag[w_eidx]   <= w_etag;
      r_ctr[w_eidx]   <= w_ctr_nxt;
      if (w_wr_tgt) begin
        r_target[w_eidx] <= pctargete_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_predd       <= 1'b0;
      r_prede       <= 1'b0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (flushd_i) begin
        r_predd <= 1'b0;
      end else if (!stalld_i) begin
        r_predd <= predict_takenf_o;
      end
      r_prede <= flushe_i ? 1'b0 : r_predd;
      if (w_upd) begin
        if (r_branch_cnt != 32'hFFFF_FFFF) begin
          r_branch_cnt <= r_branch_cnt + 32'd1;
        end
        if ((r_prede != pcsrce_i) && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
          r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
      end
    end
  end

  assign branch_count_o     = r_branch_cnt;
  assign mispredict_count_o = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_module_bpu.sv
//------------------------------------------------------------------------------
// tb_module_bpu
//   Directed-vector bench for module_bpu (ENTRIES=16, XLEN=32).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_module_bpu;

  logic        clk_i;
  logic        rst_n_i;
  logic [31:0] pcf_i;
  logic        predict_takenf_o;
  logic [31:0] pc_predf_o;
  logic        stalld_i;
  logic        flushd_i;
  logic        flushe_i;
  logic        prediction_bite_o;
  logic        branche_i;
  logic        jumpe_i;
  logic        pcsrce_i;
  logic [31:0] pce_i;
  logic [31:0] pctargete_i;
  logic [31:0] branch_count_o;
  logic [31:0] mispredict_count_o;

  int n_pass;
  int n_total;

  module_bpu #(.ENTRIES(16), .XLEN(32)) u_dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .pcf_i              (pcf_i),
    .predict_takenf_o   (predict_takenf_o),
    .pc_predf_o         (pc_predf_o),
    .stalld_i           (stalld_i),
    .flushd_i           (flushd_i),
    .flushe_i           (flushe_i),
    .prediction_bite_o  (prediction_bite_o),
    .branche_i          (branche_i),
    .jumpe_i            (jumpe_i),
    .pcsrce_i           (pcsrce_i),
    .pce_i              (pce_i),
    .pctargete_i        (pctargete_i),
    .branch_count_o     (branch_count_o),
    .mispredict_count_o (mispredict_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] np);
    pcf_i = pc;
    #1;
    chk({tag, "_pred"}, {31'd0, predict_takenf_o}, {31'd0, pt});
    chk({tag, "_pc"}, pc_predf_o, np);
    pcf_i = 32'h0;
  endtask

  task automatic counts(input string tag, input logic [31:0] b, input logic [31:0] m);
    #1;
    chk({tag, "_bcnt"}, branch_count_o, b);
    chk({tag, "_mcnt"}, mispredict_count_o, m);
  endtask

  // One resolve cycle; returns at the following negedge with update applied.
  task automatic resolve(input logic br, input logic jp, input logic tk,
                         input logic [31:0] pc, input logic [31:0] tgt);
    @(negedge clk_i);
    branche_i   = br;
    jumpe_i     = jp;
    pcsrce_i    = tk;
    pce_i       = pc;
    pctargete_i = tgt;
    @(negedge clk_i);
    branche_i = 1'b0;
    jumpe_i   = 1'b0;
    pcsrce_i  = 1'b0;
  endtask

  task automatic bite(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, prediction_bite_o}, {31'd0, exp});
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n_i = 1'b0; pcf_i = 32'h0; stalld_i = 1'b0; flushd_i = 1'b0; flushe_i = 1'b0;
    branche_i = 1'b0; jumpe_i = 1'b0; pcsrce_i = 1'b0; pce_i = 32'h0; pctargete_i = 32'h0;

    repeat (2) @(negedge clk_i);
    look("rst", 32'h0, 1'b0, 32'h4);
    bite("rst_bite", 1'b0);
    counts("rst", 32'd0, 32'd0);
    rst_n_i = 1'b1;

    for (int a = 0; a <= 32'h3C; a += 4) begin
      @(negedge clk_i);
      look("sweep", a, 1'b0, a + 4);
    end
    counts("sweep", 32'd0, 32'd0);

    resolve(1'b1, 1'b0, 1'b1, 32'h100, 32'h80);
    look("first_taken", 32'h100, 1'b1, 32'h80);
    counts("first_taken", 32'd1, 32'd1);

    repeat (3) resolve(1'b1, 1'b0, 1'b1, 32'h100, 32'h80);
    resolve(1'b1, 1'b0, 1'b0, 32'h100, 32'h999);
    look("hyst_nt1", 32'h100, 1'b1, 32'h80);
    resolve(1'b1, 1'b0, 1'b0, 32'h100, 32'h999);
    look("hyst_nt2", 32'h100, 1'b0, 32'h104);
    counts("hyst", 32'd6, 32'd4);

    resolve(1'b1, 1'b0, 1'b1, 32'h100, 32'h80);
    look("alias_miss", 32'h140, 1'b0, 32'h144);
    look("alias_orig", 32'h100, 1'b1, 32'h80);
    resolve(1'b1, 1'b0, 1'b1, 32'h140, 32'h300);
    look("alias_new", 32'h140, 1'b1, 32'h300);
    look("alias_evict", 32'h100, 1'b0, 32'h104);
    counts("alias", 32'd8, 32'd6);

    // Decode stall holds predd, so the F prediction enters D only on release.
    @(negedge clk_i); pcf_i = 32'h140; stalld_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i); bite("stall_held", 1'b0); stalld_i = 1'b0;
    @(negedge clk_i); bite("stall_d", 1'b0); pcf_i = 32'h0;
    @(negedge clk_i); bite("stall_e", 1'b1);
    @(negedge clk_i); bite("stall_after", 1'b0);

    @(negedge clk_i); pcf_i = 32'h140;
    @(negedge clk_i); pcf_i = 32'h0; flushe_i = 1'b1;
    @(negedge clk_i); flushe_i = 1'b0; bite("flushe", 1'b0);
    @(negedge clk_i); bite("flushe_after", 1'b0);

    @(negedge clk_i); pcf_i = 32'h140;
    @(negedge clk_i); pcf_i = 32'h0; flushd_i = 1'b1; stalld_i = 1'b1;
    @(negedge clk_i); flushd_i = 1'b0; stalld_i = 1'b0; bite("flushd_prev", 1'b1);
    @(negedge clk_i); bite("flushd_clr", 1'b0);

    @(negedge clk_i);
    look("pre_rst", 32'h140, 1'b1, 32'h300);
    rst_n_i = 1'b0;
    look("mid_rst", 32'h140, 1'b0, 32'h144);
    counts("mid_rst", 32'd0, 32'd0);
    @(negedge clk_i); rst_n_i = 1'b1;
    look("post_rst", 32'h140, 1'b0, 32'h144);

    @(negedge clk_i);
    branche_i = 1'b1; pcsrce_i = 1'b1; pce_i = 32'h200; pctargete_i = 32'h400;
    look("same_cyc", 32'h200, 1'b0, 32'h204);
    @(negedge clk_i);
    branche_i = 1'b0; pcsrce_i = 1'b0;
    look("next_cyc", 32'h200, 1'b1, 32'h400);
    repeat (3) resolve(1'b1, 1'b0, 1'b0, 32'h200, 32'h400);
    counts("four_res", 32'd4, 32'd1);

    resolve(1'b1, 1'b1, 1'b1, 32'h20, 32'h800);
    resolve(1'b1, 1'b0, 1'b0, 32'h20, 32'h999);
    look("jump_strong", 32'h20, 1'b1, 32'h800);
    counts("jump", 32'd6, 32'd2);

    @(negedge clk_i); pcf_i = 32'h20;
    @(negedge clk_i); pcf_i = 32'h0;
    @(negedge clk_i); bite("mp_bite", 1'b1);
    branche_i = 1'b1; pcsrce_i = 1'b0; pce_i = 32'h20;
    @(negedge clk_i); branche_i = 1'b0;
    counts("mp_nt", 32'd7, 32'd3);
    look("mp_weak", 32'h20, 1'b0, 32'h24);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
